step4_converge: RTL and testbench

Convergence stage of the PBVI backup loop. Consumes the per-belief-point alpha vectors and chosen actions produced by the step3 best-action selector. Compares each new point value against the value under the previous iteration's alpha set, tracks the maximum absolute change, and flags convergence. The new set is then retained as the reference for the next iteration, and the controller uses the verdict to stop or re-issue a backup.

---
 rtl/step4_converge.sv | 142 ++++++++++++++
 tb/tb_step4_converge.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/step4_converge.sv
// PBVI convergence stage: scans one belief point per cycle, tracks the max value change
// against the previous alpha set, then retains the new set. Optional macro: STEP4_ACTION_CHANGE_EN.
module step4_converge #(
    parameter int           N_POINTS = 16,
    parameter int           W        = 16,
    parameter logic [2*W:0] EPS      = 33'd64
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              en,
    input  logic                              clr,
    input  logic [N_POINTS-1:0][1:0][W-1:0]   alpha_in,
    input  logic [N_POINTS-1:0][1:0][W-1:0]   point_belief,
    input  logic [N_POINTS-1:0][1:0]          point_action_in,
    output logic                              busy,
    output logic                              done,
    output logic                              converged,
    output logic [2*W:0]                      max_delta,
    output logic [7:0]                        iter_count,
    output logic [4:0]                        action_changes
);
    localparam int            IW   = (N_POINTS > 1) ? $clog2(N_POINTS) : 1;
    localparam logic [IW-1:0] LAST = IW'(N_POINTS - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    state_t state_q, state_d;

    logic [N_POINTS-1:0][1:0][W-1:0] alpha_q, belief_q, prev_alpha_q;
    logic [IW-1:0]  idx_q;
    logic [2*W:0]   run_max_q, max_delta_q;
    logic           prev_valid_q, conv_q;
    logic [7:0]     iter_q;
    logic [2*W-1:0] pn0, pn1, po0, po1;
    logic [2*W:0]   v_new, v_old, d, max_fin;
    logic           ac_ok;
    logic           last_pt;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en) state_d = SCAN;
            SCAN:    if (idx_q == LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Per-point value under the new and previous alpha; sums are one bit wider than products.
    always_comb begin
        pn0     = (2*W)'(belief_q[idx_q][0]) * (2*W)'(alpha_q[idx_q][0]);
        pn1     = (2*W)'(belief_q[idx_q][1]) * (2*W)'(alpha_q[idx_q][1]);
        po0     = (2*W)'(belief_q[idx_q][0]) * (2*W)'(prev_alpha_q[idx_q][0]);
        po1     = (2*W)'(belief_q[idx_q][1]) * (2*W)'(prev_alpha_q[idx_q][1]);
        v_new   = (2*W+1)'(pn0) + (2*W+1)'(pn1);
        v_old   = (2*W+1)'(po0) + (2*W+1)'(po1);
        d       = (v_new >= v_old) ? (v_new - v_old) : (v_old - v_new);
        max_fin = (d > run_max_q) ? d : run_max_q;
    end

    assign last_pt    = (state_q == SCAN) && (idx_q == LAST);
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign converged  = conv_q;
    assign max_delta  = max_delta_q;
    assign iter_count = iter_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            alpha_q      <= '0;
            belief_q     <= '0;
            prev_alpha_q <= '0;
            idx_q        <= '0;
            run_max_q    <= '0;
            max_delta_q  <= '0;
            prev_valid_q <= 1'b0;
            conv_q       <= 1'b0;
            iter_q       <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE) begin
                // clr clears history before a same-cycle start snapshots new inputs
                if (clr) begin
                    prev_valid_q <= 1'b0;
                    iter_q       <= '0;
                    prev_alpha_q <= '0;
                end
                if (en) begin
                    alpha_q   <= alpha_in;
                    belief_q  <= point_belief;
                    idx_q     <= '0;
                    run_max_q <= '0;
                end
            end else if (state_q == SCAN) begin
                idx_q     <= idx_q + IW'(1);
                run_max_q <= max_fin;
                if (last_pt) begin
                    max_delta_q  <= max_fin;
                    conv_q       <= prev_valid_q && (max_fin <= EPS) && ac_ok;
                    prev_alpha_q <= alpha_q;
                    prev_valid_q <= 1'b1;
                    iter_q       <= (iter_q == 8'hFF) ? iter_q : iter_q + 8'd1;
                end
            end
        end
    end

`ifdef STEP4_ACTION_CHANGE_EN
    logic [N_POINTS-1:0][1:0] act_q, prev_act_q;
    logic [4:0]               ac_cnt_q, ac_fin, ac_q;

    assign ac_fin         = ac_cnt_q + 5'(act_q[idx_q] != prev_act_q[idx_q]);
    assign ac_ok          = (ac_fin == 5'd0);
    assign action_changes = ac_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_q      <= '0;
            prev_act_q <= '0;
            ac_cnt_q   <= '0;
            ac_q       <= '0;
        end else if (state_q == IDLE) begin
            if (clr) prev_act_q <= '0;
            if (en) begin
                act_q    <= point_action_in;
                ac_cnt_q <= '0;
            end
        end else if (state_q == SCAN) begin
            ac_cnt_q <= ac_fin;
            if (last_pt) begin
                ac_q       <= ac_fin;
                prev_act_q <= act_q;
            end
        end
    end
`else
    logic unused_act;
    assign unused_act     = ^point_action_in;
    assign ac_ok          = 1'b1;
    assign action_changes = '0;
`endif
endmodule

// File: tb/tb_step4_converge.sv
// Self-checking bench for step4_converge: directed scenarios plus randomized iterations
// checked against a per-iteration arithmetic model of the convergence rules.
module tb_step4_converge;
    localparam int          N   = 16;
    localparam int          W   = 16;
    localparam logic [32:0] EPS = 33'd64;

    logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, clr = 1'b0;
    logic [N-1:0][1:0][W-1:0] alpha_in, point_belief;
    logic [N-1:0][1:0]        point_action_in;
    logic        busy, done, converged;
    logic [32:0] max_delta;
    logic [7:0]  iter_count;
    logic [4:0]  action_changes;

    always #5 clk = ~clk;

    step4_converge #(.N_POINTS(N), .W(W), .EPS(EPS)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
        .alpha_in(alpha_in), .point_belief(point_belief), .point_action_in(point_action_in),
        .busy(busy), .done(done), .converged(converged), .max_delta(max_delta),
        .iter_count(iter_count), .action_changes(action_changes)
    );

    int checks = 0, errors = 0;

    // Reference state: previous alpha set, previous actions, history flag, iteration count.
    longint      m_pa[N][2];
    int          m_pact[N];
    bit          m_valid;
    int          m_iter;
    logic [32:0] e_md;
    bit          e_conv;
    int          e_ac;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pa[i][0] = 0; m_pa[i][1] = 0; m_pact[i] = 0;
        end
        m_valid = 0; m_iter = 0;
    endtask

    // Evaluates one iteration on the inputs currently applied, then retains them as history.
    task automatic model_iter(input bit with_clr);
        longint vn, vo, dd, md;
        int ac;
        if (with_clr) model_reset();
        md = 0; ac = 0;
        for (int i = 0; i < N; i++) begin
            vn = longint'(point_belief[i][0]) * longint'(alpha_in[i][0])
               + longint'(point_belief[i][1]) * longint'(alpha_in[i][1]);
            vo = longint'(point_belief[i][0]) * m_pa[i][0]
               + longint'(point_belief[i][1]) * m_pa[i][1];
            dd = (vn > vo) ? vn - vo : vo - vn;
            if (dd > md) md = dd;
            if (int'(point_action_in[i]) != m_pact[i]) ac++;
        end
        e_md = 33'(md);
`ifdef STEP4_ACTION_CHANGE_EN
        e_ac   = ac;
        e_conv = m_valid && (md <= longint'(EPS)) && (ac == 0);
`else
        e_ac   = 0;
        e_conv = m_valid && (md <= longint'(EPS));
`endif
        for (int i = 0; i < N; i++) begin
            m_pa[i][0] = longint'(alpha_in[i][0]);
            m_pa[i][1] = longint'(alpha_in[i][1]);
            m_pact[i]  = int'(point_action_in[i]);
        end
        m_valid = 1;
        m_iter  = (m_iter < 255) ? m_iter + 1 : 255;
    endtask

    task automatic set_all(input int b0, input int b1, input int a0, input int a1, input logic [1:0] act);
        for (int i = 0; i < N; i++) begin
            point_belief[i][0] = W'(b0); point_belief[i][1] = W'(b1);
            alpha_in[i][0]     = W'(a0); alpha_in[i][1]     = W'(a1);
            point_action_in[i] = act;
        end
    endtask

    // Waits for idle, pulses en (optionally with clr), returns cycles from start edge to done (-1 on timeout).
    task automatic kick(input bit with_clr, output int cyc);
        for (int c = 0; c < 40 && busy; c++) begin @(posedge clk); #1; end
        en = 1'b1; clr = with_clr;
        @(posedge clk); #1;
        en = 1'b0; clr = 1'b0;
        cyc = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (done) begin cyc = c; break; end
        end
    endtask

    task automatic test_reset();
        set_all(0, 0, 0, 0, 2'b00);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0)       begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if (converged !== 1'b0)  begin errors++; $display("FAIL reset_conv got %b exp 0", converged); end
        checks++; if (max_delta !== 33'd0) begin errors++; $display("FAIL reset_md got %0d exp 0", max_delta); end
        checks++; if (iter_count !== 8'd0) begin errors++; $display("FAIL reset_iter got %0d exp 0", iter_count); end
        checks++; if (action_changes !== 5'd0) begin errors++; $display("FAIL reset_ac got %0d exp 0", action_changes); end
        model_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_first_iter();
        int cyc;
        set_all(1, 0, 10, 20, 2'b00);
        model_iter(1'b0);
        kick(1'b0, cyc);
        checks++; if (cyc != 16)            begin errors++; $display("FAIL first_latency got %0d exp 16", cyc); end
        checks++; if (max_delta !== 33'd10) begin errors++; $display("FAIL first_md got %0d exp 10", max_delta); end
        checks++; if (converged !== 1'b0)   begin errors++; $display("FAIL first_conv got %b exp 0", converged); end
        checks++; if (iter_count !== 8'd1)  begin errors++; $display("FAIL first_iter got %0d exp 1", iter_count); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL first_after got done=%b busy=%b exp 0/0", done, busy); end
    endtask

    task automatic test_identical_repeat();
        int cyc;
        model_iter(1'b0);
        kick(1'b0, cyc);
        checks++; if (max_delta !== 33'd0) begin errors++; $display("FAIL repeat_md got %0d exp 0", max_delta); end
        checks++; if (converged !== 1'b1)  begin errors++; $display("FAIL repeat_conv got %b exp 1", converged); end
        checks++; if (iter_count !== 8'd2) begin errors++; $display("FAIL repeat_iter got %0d exp 2", iter_count); end
    endtask

    task automatic test_threshold();
        int cyc;
        alpha_in[5][0] = 16'd110;
        model_iter(1'b0); kick(1'b0, cyc);
        checks++; if (max_delta !== 33'd100) begin errors++; $display("FAIL thr_over_md got %0d exp 100", max_delta); end
        checks++; if (converged !== 1'b0)    begin errors++; $display("FAIL thr_over_conv got %b exp 0", converged); end
        set_all(1, 0, 10, 20, 2'b00);
        model_iter(1'b0); kick(1'b0, cyc);
        checks++; if (max_delta !== e_md) begin errors++; $display("FAIL thr_back_md got %0d exp %0d", max_delta, e_md); end
        alpha_in[5][0] = 16'd74;
        model_iter(1'b0); kick(1'b0, cyc);
        checks++; if (max_delta !== 33'd64) begin errors++; $display("FAIL thr_edge_md got %0d exp 64", max_delta); end
        checks++; if (converged !== 1'b1)   begin errors++; $display("FAIL thr_edge_conv got %b exp 1", converged); end
    endtask

    task automatic test_start_while_busy();
        int ndone, lat;
        logic [32:0] md_cap;
        logic conv_cap;
        ndone = 0; lat = -1; md_cap = '0; conv_cap = 1'b0;
        for (int c = 0; c < 40 && busy; c++) begin @(posedge clk); #1; end
        alpha_in[3][0] = 16'd50;
        model_iter(1'b0);
        en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_scan got %b exp 1", busy); end
            end
            if (c == 3) begin
                en = 1'b1; alpha_in[3][0] = 16'd500; alpha_in[0][0] = 16'd999;
            end else en = 1'b0;
            if (done) begin
                ndone++;
                if (ndone == 1) begin lat = c; md_cap = max_delta; conv_cap = converged; end
            end
        end
        checks++; if (ndone != 1)       begin errors++; $display("FAIL busy_ndone got %0d exp 1", ndone); end
        checks++; if (lat != 16)        begin errors++; $display("FAIL busy_latency got %0d exp 16", lat); end
        checks++; if (md_cap !== e_md)  begin errors++; $display("FAIL busy_md got %0d exp %0d", md_cap, e_md); end
        checks++; if (conv_cap !== e_conv) begin errors++; $display("FAIL busy_conv got %b exp %b", conv_cap, e_conv); end
    endtask

    task automatic test_reset_mid_scan();
        int cyc;
        set_all(3, 5, 1000, 2000, 2'b01);
        en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b exp 1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mid_rst_ctl got busy=%b done=%b exp 0/0", busy, done); end
        checks++; if (converged !== 1'b0)  begin errors++; $display("FAIL mid_rst_conv got %b exp 0", converged); end
        checks++; if (max_delta !== 33'd0) begin errors++; $display("FAIL mid_rst_md got %0d exp 0", max_delta); end
        checks++; if (iter_count !== 8'd0) begin errors++; $display("FAIL mid_rst_iter got %0d exp 0", iter_count); end
        checks++; if (action_changes !== 5'd0) begin errors++; $display("FAIL mid_rst_ac got %0d exp 0", action_changes); end
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        set_all(1, 0, 10, 20, 2'b00);
        model_iter(1'b0); kick(1'b0, cyc);
        checks++; if (converged !== 1'b0)  begin errors++; $display("FAIL post_rst_conv got %b exp 0", converged); end
        checks++; if (iter_count !== 8'd1) begin errors++; $display("FAIL post_rst_iter got %0d exp 1", iter_count); end
        checks++; if (max_delta !== 33'd10) begin errors++; $display("FAIL post_rst_md got %0d exp 10", max_delta); end
    endtask

    task automatic test_action_change();
        int cyc;
        set_all(1, 0, 10, 20, 2'b00);
        model_iter(1'b0); kick(1'b0, cyc);
        point_action_in[0] = 2'b10; point_action_in[7] = 2'b10;
        model_iter(1'b0); kick(1'b0, cyc);
        checks++; if (max_delta !== 33'd0) begin errors++; $display("FAIL act_md got %0d exp 0", max_delta); end
`ifdef STEP4_ACTION_CHANGE_EN
        checks++; if (action_changes !== 5'd2) begin errors++; $display("FAIL act_count got %0d exp 2", action_changes); end
        checks++; if (converged !== 1'b0)      begin errors++; $display("FAIL act_conv got %b exp 0", converged); end
`else
        checks++; if (action_changes !== 5'd0) begin errors++; $display("FAIL act_count got %0d exp 0", action_changes); end
        checks++; if (converged !== 1'b1)      begin errors++; $display("FAIL act_conv got %b exp 1", converged); end
`endif
    endtask

    task automatic test_clr_with_en();
        int cyc;
        model_iter(1'b1); kick(1'b1, cyc);
        checks++; if (converged !== 1'b0)  begin errors++; $display("FAIL clr_conv got %b exp 0", converged); end
        checks++; if (iter_count !== 8'd1) begin errors++; $display("FAIL clr_iter got %0d exp 1", iter_count); end
        checks++; if (max_delta !== 33'd10) begin errors++; $display("FAIL clr_md got %0d exp 10", max_delta); end
    endtask

    task automatic test_random();
        int cyc, mode, p;
        bit wc;
        for (int it = 0; it < 16; it++) begin
            mode = $urandom_range(0, 2);
            p    = $urandom_range(0, N-1);
            for (int i = 0; i < N; i++) begin
                if (mode == 0) begin
                    point_belief[i][0] = W'($urandom); point_belief[i][1] = W'($urandom);
                    alpha_in[i][0]     = W'($urandom); alpha_in[i][1]     = W'($urandom);
                end else if (mode == 1) begin
                    point_belief[i][0] = W'($urandom_range(0, 3));
                    point_belief[i][1] = W'($urandom_range(0, 3));
                end
                if ($urandom_range(0, 7) == 0) point_action_in[i] = 2'($urandom);
            end
            if (mode == 1) alpha_in[p][$urandom_range(0, 1)] += W'($urandom_range(0, 30));
            wc = ($urandom_range(0, 4) == 0);
            model_iter(wc); kick(wc, cyc);
            checks++; if (cyc != 16)           begin errors++; $display("FAIL rnd%0d_latency got %0d exp 16", it, cyc); end
            checks++; if (max_delta !== e_md)  begin errors++; $display("FAIL rnd%0d_md got %0d exp %0d", it, max_delta, e_md); end
            checks++; if (converged !== e_conv) begin errors++; $display("FAIL rnd%0d_conv got %b exp %b", it, converged, e_conv); end
            checks++; if (iter_count !== 8'(m_iter)) begin errors++; $display("FAIL rnd%0d_iter got %0d exp %0d", it, iter_count, m_iter); end
            checks++; if (action_changes !== 5'(e_ac)) begin errors++; $display("FAIL rnd%0d_ac got %0d exp %0d", it, action_changes, e_ac); end
        end
    endtask

    task automatic test_back_to_back();
        int cyc, ndone;
        bit seen_idle, dropped;
        logic [32:0] md_cap;
        logic conv_cap;
        set_all(2, 7, 300, 40, 2'b00);
        model_iter(1'b0); kick(1'b0, cyc);
        alpha_in[9][1] = 16'd47;
        model_iter(1'b0);
        en = 1'b1;
        ndone = 0; seen_idle = 0; dropped = 0; md_cap = '0; conv_cap = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (!busy) seen_idle = 1;
            if (seen_idle && busy && !dropped) begin en = 1'b0; dropped = 1; end
            if (done) begin ndone++; md_cap = max_delta; conv_cap = converged; end
        end
        en = 1'b0;
        checks++; if (ndone != 1)         begin errors++; $display("FAIL b2b_ndone got %0d exp 1", ndone); end
        checks++; if (md_cap !== e_md)    begin errors++; $display("FAIL b2b_md got %0d exp %0d", md_cap, e_md); end
        checks++; if (conv_cap !== e_conv) begin errors++; $display("FAIL b2b_conv got %b exp %b", conv_cap, e_conv); end
    endtask

    task automatic test_iter_saturation();
        int cyc;
        for (int it = 0; it < 260; it++) begin
            model_iter(1'b0); kick(1'b0, cyc);
        end
        checks++; if (iter_count !== 8'd255) begin errors++; $display("FAIL sat_iter got %0d exp 255", iter_count); end
        checks++; if (converged !== e_conv)  begin errors++; $display("FAIL sat_conv got %b exp %b", converged, e_conv); end
    endtask

    initial begin
        test_reset();
        test_first_iter();
        test_identical_repeat();
        test_threshold();
        test_start_while_busy();
        test_reset_mid_scan();
        test_action_change();
        test_clr_with_en();
        test_random();
        test_back_to_back();
        test_iter_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
